// File: rtl/stepper_phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stepper_pkg
// Brief    : Shared phase table, FSM encoding and widths for the stepper sequencer.
// Revision : 1.0
// ============================================================================
package stepper_pkg;

    localparam int SPEED_W = 2;

    // Index order {A,B,C,D}: even entries energise one coil, odd entries two.
    localparam logic [3:0] PHASE_TABLE [0:7] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stepper_phase_sequencer_edge_rise.sv
`default_nettype none
// ============================================================================
// Module   : edge_rise
// Brief    : Rising-edge detector on an already synchronised level.
// Revision : 1.0
// ============================================================================
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= d;
        end
    end

    assign pulse = d & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/stepper_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stepper_phase_sequencer
// Brief    : Rate-divided coil phase sequencer with direction, half/full step
//            and a button-cycled speed select.
// Revision : 1.0
// ============================================================================
module stepper_phase_sequencer
    import stepper_pkg::*;
#(
    parameter int DIV_BASE = 250000,
    parameter int CTR_W    = 24,
    parameter int HOLD     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_in,
    input  logic               dir_in,
    input  logic               speed_btn,
    input  logic               half_in,
    output logic [3:0]         coil,
    output logic               step_pulse,
    output logic [SPEED_W-1:0] speed_idx,
    output logic               busy
);

    localparam logic [CTR_W-1:0] C_DIV      = CTR_W'(DIV_BASE);
    localparam logic [CTR_W-1:0] C_ONE      = CTR_W'(1);
    localparam logic [3:0]       C_COIL_OFF = 4'b0000;
    localparam bit               C_HOLD     = (HOLD != 0);

    state_t           r_state;
    logic [CTR_W-1:0] r_ctr;
    logic [2:0]       r_idx;

    logic             w_speed_edge;
    logic [CTR_W-1:0] w_period;
    logic             w_terminal;
    logic [2:0]       w_next_idx;
    logic [3:0]       w_idle_coil;

    edge_rise u_speed_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (speed_btn),
        .pulse (w_speed_edge)
    );

    always_comb begin
        w_period   = C_DIV >> speed_idx;
        w_terminal = (r_ctr == (w_period - C_ONE));
        // Full step lands on the odd (two-coil) entries regardless of start index.
        if (half_in) begin
            w_next_idx = dir_in ? (r_idx + 3'd1) : (r_idx - 3'd1);
        end else begin
            w_next_idx = (dir_in ? (r_idx + 3'd2) : (r_idx - 3'd2)) | 3'b001;
        end
        w_idle_coil = C_HOLD ? PHASE_TABLE[r_idx] : C_COIL_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ctr      <= '0;
            r_idx      <= 3'd0;
            speed_idx  <= '0;
            coil       <= C_COIL_OFF;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (w_speed_edge) begin
                speed_idx <= speed_idx + SPEED_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    r_ctr <= '0;
                    if (en_in) begin
                        r_state <= ST_RUN;
                        busy    <= 1'b1;
                        coil    <= PHASE_TABLE[r_idx];
                    end else begin
                        coil    <= w_idle_coil;
                    end
                end
                ST_RUN: begin
                    // Disable and speed change both beat a terminal count.
                    if (!en_in) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        r_ctr   <= '0;
                        coil    <= w_idle_coil;
                    end else if (w_speed_edge) begin
                        r_ctr   <= '0;
                    end else if (w_terminal) begin
                        r_ctr      <= '0;
                        r_idx      <= w_next_idx;
                        coil       <= PHASE_TABLE[w_next_idx];
                        step_pulse <= 1'b1;
                    end else begin
                        r_ctr   <= r_ctr + C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    r_ctr   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stepper_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stepper_phase_sequencer
// Brief    : Randomised bench for two sequencer instances (HOLD=1 / HOLD=0)
//            against a deadline-based reference model.
// Revision : 1.0
// ============================================================================
module tb_stepper_phase_sequencer;

    localparam int DIVB  = 64;
    localparam int N_CYC = 6000;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       en_in     = 1'b0;
    logic       dir_in    = 1'b1;
    logic       speed_btn = 1'b0;
    logic       half_in   = 1'b1;

    logic [3:0] coil_h, coil_f;
    logic       pulse_h, pulse_f, busy_h, busy_f;
    logic [1:0] spd_h, spd_f;

    int checks   = 0;
    int failures = 0;

    // Reference model: absolute edge count, next step deadline, phase index.
    logic [3:0] tbl [8];
    int         m_t;
    int         m_due;
    int         m_idx;
    int         m_speed;
    bit         m_run;
    bit         m_prev;
    bit         m_pulse;
    logic [3:0] m_coil_h;
    logic [3:0] m_coil_f;
    bit         did_reset = 1'b0;

    always #5 clk = ~clk;

    stepper_phase_sequencer #(.DIV_BASE(DIVB), .CTR_W(24), .HOLD(1)) u_dut_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_in      (en_in),
        .dir_in     (dir_in),
        .speed_btn  (speed_btn),
        .half_in    (half_in),
        .coil       (coil_h),
        .step_pulse (pulse_h),
        .speed_idx  (spd_h),
        .busy       (busy_h)
    );

    stepper_phase_sequencer #(.DIV_BASE(DIVB), .CTR_W(24), .HOLD(0)) u_dut_free (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_in      (en_in),
        .dir_in     (dir_in),
        .speed_btn  (speed_btn),
        .half_in    (half_in),
        .coil       (coil_f),
        .step_pulse (pulse_f),
        .speed_idx  (spd_f),
        .busy       (busy_f)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, "_coil_h"},  32'(coil_h),  32'(m_coil_h));
        check_eq({ph, "_coil_f"},  32'(coil_f),  32'(m_coil_f));
        check_eq({ph, "_pulse_h"}, 32'(pulse_h), 32'(m_pulse));
        check_eq({ph, "_pulse_f"}, 32'(pulse_f), 32'(m_pulse));
        check_eq({ph, "_spd_h"},   32'(spd_h),   32'(m_speed));
        check_eq({ph, "_spd_f"},   32'(spd_f),   32'(m_speed));
        check_eq({ph, "_busy_h"},  32'(busy_h),  32'(m_run));
        check_eq({ph, "_busy_f"},  32'(busy_f),  32'(m_run));
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_idx    = 0;
        m_speed  = 0;
        m_prev   = 1'b0;
        m_pulse  = 1'b0;
        m_due    = 0;
        m_coil_h = 4'b0000;
        m_coil_f = 4'b0000;
    endtask

    // Effect of one rising clock edge given the input levels held across it.
    task automatic model_edge(input bit en_v, input bit dir_v, input bit half_v, input bit btn_v);
        bit sedge;
        int per;
        sedge   = btn_v && !m_prev;
        m_prev  = btn_v;
        m_t     = m_t + 1;
        m_pulse = 1'b0;
        if (sedge) m_speed = (m_speed + 1) % 4;
        per = DIVB / (1 << m_speed);
        if (!m_run) begin
            if (en_v) begin
                m_run = 1'b1;
                m_due = m_t + per;
            end
        end else if (!en_v) begin
            m_run = 1'b0;
        end else if (sedge) begin
            m_due = m_t + per;
        end else if (m_t == m_due) begin
            if (half_v) m_idx = (m_idx + (dir_v ? 1 : 7)) % 8;
            else        m_idx = ((m_idx + (dir_v ? 2 : 6)) % 8) | 1;
            m_pulse = 1'b1;
            m_due   = m_t + per;
        end
        m_coil_h = tbl[m_idx];
        m_coil_f = m_run ? tbl[m_idx] : 4'b0000;
    endtask

    task automatic drive(input int cyc);
        bit term;
        term = m_run && (m_due == m_t + 1);
        if (cyc < 600) begin
            en_in = 1'b1; dir_in = 1'b1; half_in = 1'b1; speed_btn = 1'b0;
        end else if (cyc < 1100) begin
            en_in = 1'b1; dir_in = (cyc < 900); half_in = 1'b0; speed_btn = 1'b0;
        end else begin
            if (en_in) begin
                if ($urandom_range(0, 399) == 0 || (term && $urandom_range(0, 15) == 0))
                    en_in = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                en_in = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) dir_in  = ~dir_in;
            if ($urandom_range(0, 299) == 0) half_in = ~half_in;
            if (speed_btn) begin
                if ($urandom_range(0, 19) == 0) speed_btn = 1'b0;
            end else if ((term && $urandom_range(0, 2) == 0) || $urandom_range(0, 499) == 0) begin
                speed_btn = 1'b1;
            end
        end
    endtask

    initial begin
        tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
        m_t = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            drive(cyc);
            model_edge(en_in, dir_in, half_in, speed_btn);
            @(negedge clk);
            check_outputs("run");
            if (!did_reset && cyc > 3000 && m_run && m_coil_h == 4'b0110) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("arst_coil_h", 32'(coil_h), 32'h0);
                check_eq("arst_coil_f", 32'(coil_f), 32'h0);
                check_eq("arst_spd",    32'(spd_h),  32'h0);
                check_eq("arst_busy",   32'(busy_h), 32'h0);
                model_reset();
                did_reset = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                check_outputs("post_rst");
            end
        end
        check_eq("arst_seen", 32'(did_reset), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
